// File: rtl/x25519_input_loader.sv
// Loads a 32-byte X25519 scalar and a 32-byte u-coordinate from a byte stream,
// clamps the scalar, masks and reduces u mod 2^255-19, then holds both operands for handoff.
module x25519_input_loader (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [254:0] k,
  output logic [254:0] x_p,
  output logic         noncanon
);

  localparam int unsigned FW = 255;
  localparam int unsigned CW = 5;
  localparam logic [CW-1:0] LAST_BYTE = CW'(31);
  localparam logic [FW-1:0] P = {FW{1'b1}} - FW'(18);

  typedef enum logic [1:0] {
    LOAD_K = 2'd0,
    LOAD_U = 2'd1,
    REDUCE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          loading;
  logic [FW-1:0] k_asm;
  logic [FW-1:0] u_asm;

  // Bit 255 of either operand is never stored; the scalar clamp is folded into
  // the first and last byte writes so k_asm already holds the clamped scalar.
  assign in_ready = loading & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD_K;
      cnt       <= '0;
      loading   <= 1'b1;
      out_valid <= 1'b0;
      k_asm     <= '0;
      u_asm     <= '0;
      k         <= '0;
      x_p       <= '0;
      noncanon  <= 1'b0;
    end else begin
      case (state)
        LOAD_K: begin
          if (in_valid) begin
            if (cnt == LAST_BYTE) begin
              k_asm[254:248] <= {1'b1, in_data[5:0]};
              state          <= LOAD_U;
            end else if (cnt == CW'(0)) begin
              k_asm[7:0] <= {in_data[7:3], 3'b000};
            end else begin
              k_asm[{cnt, 3'b000} +: 8] <= in_data;
            end
            cnt <= cnt + CW'(1);
          end
        end
        LOAD_U: begin
          if (in_valid) begin
            if (cnt == LAST_BYTE) begin
              u_asm[254:248] <= in_data[6:0];
              state          <= REDUCE;
              loading        <= 1'b0;
            end else begin
              u_asm[{cnt, 3'b000} +: 8] <= in_data;
            end
            cnt <= cnt + CW'(1);
          end
        end
        REDUCE: begin
          // One conditional subtract suffices: u < 2^255 < 2p.
          k <= k_asm;
          if (u_asm >= P) begin
            x_p      <= u_asm - P;
            noncanon <= 1'b1;
          end else begin
            x_p      <= u_asm;
            noncanon <= 1'b0;
          end
          state     <= HOLD;
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) begin
            state     <= LOAD_K;
            cnt       <= '0;
            loading   <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= LOAD_K;
          cnt       <= '0;
          loading   <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_x25519_input_loader.sv
// Directed and randomized bench for x25519_input_loader, checked against a
// big-integer reference model of clamping and reduction.
module tb_x25519_input_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         out_valid;
  logic         out_ready;
  logic [254:0] k;
  logic [254:0] x_p;
  logic         noncanon;

  always #5 clk = ~clk;

  x25519_input_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .k         (k),
    .x_p       (x_p),
    .noncanon  (noncanon)
  );

  localparam logic [255:0] TWO255 = 256'd1 << 255;
  localparam logic [255:0] P256   = TWO255 - 256'd19;

  int checks = 0;
  int errors = 0;

  logic [7:0]   kb [32];
  logic [7:0]   ub [32];
  logic [254:0] exp_k;
  logic [254:0] exp_x;
  logic         exp_nc;
  logic [254:0] saved_k;
  logic [254:0] saved_x;

  task automatic chk(input string tag, input logic [254:0] obs, input logic [254:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: integer value of each little-endian operand, clamp, mask, mod p.
  task automatic model();
    logic [255:0] ka;
    logic [255:0] ua;
    ka = '0;
    ua = '0;
    for (int i = 0; i < 32; i++) begin
      ka = ka + (256'(kb[i]) << (8 * i));
      ua = ua + (256'(ub[i]) << (8 * i));
    end
    ka = (ka & ~256'd7 & ~TWO255) | (TWO255 >> 1);
    exp_k  = ka[254:0];
    ua     = ua % TWO255;
    exp_nc = (ua >= P256);
    ua     = ua % P256;
    exp_x  = ua[254:0];
  endtask

  task automatic randomize_frame();
    for (int i = 0; i < 32; i++) begin
      kb[i] = 8'($urandom);
      ub[i] = 8'($urandom);
    end
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gaps;
    int w;
    gaps = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    in_valid = 1'b0;
    for (int g = 0; g < gaps; g++) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("accept_timeout", 255'(in_ready), 255'(1'b1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int max_gap);
    for (int i = 0; i < 64; i++)
      send_byte((i < 32) ? kb[i] : ub[i - 32], max_gap);
  endtask

  // Latency: REDUCE visible one cycle after the 64th byte, HOLD the next.
  task automatic expect_result(input string tag);
    model();
    chk({tag, "_reduce_valid"}, 255'(out_valid), 255'(1'b0));
    chk({tag, "_reduce_ready"}, 255'(in_ready), 255'(1'b0));
    @(negedge clk);
    chk({tag, "_out_valid"}, 255'(out_valid), 255'(1'b1));
    chk({tag, "_k"}, k, exp_k);
    chk({tag, "_x_p"}, x_p, exp_x);
    chk({tag, "_noncanon"}, 255'(noncanon), 255'(exp_nc));
  endtask

  // With out_ready already high, the handoff edge follows; outputs are retained.
  task automatic expect_release(input string tag);
    @(negedge clk);
    chk({tag, "_rel_valid"}, 255'(out_valid), 255'(1'b0));
    chk({tag, "_rel_ready"}, 255'(in_ready), 255'(1'b1));
    chk({tag, "_rel_k_kept"}, k, exp_k);
    chk({tag, "_rel_x_kept"}, x_p, exp_x);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 255'(in_ready), 255'(1'b0));
    chk("rst_out_valid", 255'(out_valid), 255'(1'b0));
    chk("rst_k", k, '0);
    chk("rst_x_p", x_p, '0);
    chk("rst_noncanon", 255'(noncanon), 255'(1'b0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 255'(in_ready), 255'(1'b1));

    // Base-point vector, then a stalled consumer with bytes offered in HOLD.
    for (int i = 0; i < 32; i++) begin
      kb[i] = 8'hFF;
      ub[i] = (i == 0) ? 8'h09 : 8'h00;
    end
    send_frame(0);
    expect_result("basept");
    chk("basept_k_const", k, {{252{1'b1}}, 3'b000});
    chk("basept_x_const", x_p, 255'd9);
    saved_k = k;
    saved_x = x_p;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("stall_valid", 255'(out_valid), 255'(1'b1));
      chk("stall_ready", 255'(in_ready), 255'(1'b0));
    end
    chk("stall_k", k, saved_k);
    chk("stall_x", x_p, saved_x);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    expect_release("basept");

    // All-ones u: masked to 2^255-1, reduces to 18.
    for (int i = 0; i < 32; i++) begin
      kb[i] = 8'h00;
      ub[i] = 8'hFF;
    end
    send_frame(0);
    expect_result("ones");
    chk("ones_k_const", k, 255'd1 << 254);
    chk("ones_x_const", x_p, 255'd18);
    expect_release("ones");

    // u = p and u = p-1.
    randomize_frame();
    for (int i = 0; i < 32; i++) ub[i] = (i == 0) ? 8'hED : (i == 31) ? 8'h7F : 8'hFF;
    send_frame(1);
    expect_result("u_eq_p");
    chk("u_eq_p_x_const", x_p, '0);
    chk("u_eq_p_nc_const", 255'(noncanon), 255'(1'b1));
    expect_release("u_eq_p");
    ub[0] = 8'hEC;
    send_frame(1);
    expect_result("u_pm1");
    chk("u_pm1_nc_const", 255'(noncanon), 255'(1'b0));
    expect_release("u_pm1");

    // Same random frame without and with gaps.
    randomize_frame();
    send_frame(0);
    expect_result("rnd_nogap");
    expect_release("rnd_nogap");
    send_frame(3);
    expect_result("rnd_gap");
    expect_release("rnd_gap");

    // Reset after 20 bytes discards the partial frame.
    randomize_frame();
    for (int i = 0; i < 20; i++) send_byte(kb[i], 2);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 255'(out_valid), 255'(1'b0));
    chk("mid_rst_k", k, '0);
    chk("mid_rst_x", x_p, '0);
    rst = 1'b0;
    @(negedge clk);
    randomize_frame();
    send_frame(2);
    expect_result("after_rst");
    expect_release("after_rst");

    // Back-to-back random frames with out_ready tied high.
    for (int f = 0; f < 4; f++) begin
      randomize_frame();
      if (f == 3) ub[31] = ub[31] | 8'h80;
      send_frame(f % 2);
      expect_result("b2b");
      expect_release("b2b");
    end

    // Reset while holding a result.
    out_ready = 1'b0;
    randomize_frame();
    send_frame(0);
    expect_result("hold_rst");
    rst = 1'b1;
    @(negedge clk);
    chk("hold_rst_valid", 255'(out_valid), 255'(1'b0));
    chk("hold_rst_k", k, '0);
    chk("hold_rst_nc", 255'(noncanon), 255'(1'b0));
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    randomize_frame();
    send_frame(1);
    expect_result("post_hold_rst");
    expect_release("post_hold_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/x25519_input_loader.md
X25519_INPUT_LOADER -- requirements
Module: x25519_input_loader

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst  input  1  synchronous, active-high reset.
REQ-003: in_valid  input  1  in_data carries a valid byte.
REQ-004: in_ready  output  1  block accepts a byte this cycle.
REQ-005: in_data  input  8  byte stream: 32 scalar bytes, then 32 u-coordinate bytes, each little-endian (first byte = bits 7:0).
REQ-006: out_valid  output  1  k, x_p and noncanon are valid and stable.
REQ-007: out_ready  input  1  downstream scalar-multiplication core accepts the operand pair.
REQ-008: k  output  255  clamped scalar.
REQ-009: x_p  output  255  masked u-coordinate, reduced mod p = 2^255-19.
REQ-010: noncanon  output  1  set when the masked u was >= p and was reduced.

Function
REQ-011: FSM states are LOAD_K, LOAD_U, REDUCE and HOLD; the reset state is LOAD_K.
REQ-012: in_ready = 1 exactly when state is LOAD_K or LOAD_U and rst = 0; a byte transfers on in_valid && in_ready at a rising edge.
REQ-013: A 5-bit byte counter increments per transfer, selects destination bits [8*cnt+7 : 8*cnt], and wraps 31 -> 0.
REQ-014: In LOAD_K, the transfer at cnt = 31 moves the FSM to LOAD_U; in LOAD_U, the transfer at cnt = 31 moves it to REDUCE.
REQ-015: in_valid = 0 cycles (gaps) SHALL NOT advance the counter or the state.
REQ-016: Scalar clamp applied to the 256-bit assembly: clear bits 2:0, clear bit 255, set bit 254; k = result[254:0].
REQ-017: U mask: assembled bit 255 is discarded; u = bits [254:0].
REQ-018: REDUCE lasts exactly one cycle: if u >= p, then x_p <= u - p (result in 0..18) and noncanon <= 1; else x_p <= u and noncanon <= 0; the FSM then moves to HOLD.
REQ-019: Latency: the edge accepting the 64th byte enters REDUCE; the next edge enters HOLD; out_valid = 1 from that point.
REQ-020: out_valid = 1 exactly when state is HOLD.
REQ-021: In HOLD, k, x_p and noncanon SHALL NOT change; in_ready = 0.
REQ-022: On out_valid && out_ready, the FSM returns to LOAD_K with cnt = 0, and out_valid is 0 in the following cycle.
REQ-023: k, x_p and noncanon retain their last values after handoff until overwritten by the next frame.
REQ-024: Assembly uses separate 256-bit k and u shift or indexed registers. Output k and x_p are registered; they SHALL NOT expose partially loaded frames while out_valid = 0 is visible to the consumer.
REQ-025: out_ready while out_valid = 0 SHALL have no effect.

Reset
REQ-026: With rst = 1 at an edge, the block sets state = LOAD_K, cnt = 0, out_valid = 0, k = 0, x_p = 0, noncanon = 0 and all assembly registers to 0.
REQ-027: rst has priority over any simultaneous byte or output transfer.
REQ-028: A reset mid-frame in LOAD_K, LOAD_U, REDUCE or HOLD discards the partial frame; the next 64 accepted bytes form a fresh frame.

Verification
REQ-029: Scalar bytes all 0xFF, u = 0x09 followed by 31 bytes of 0x00 -> k = 0x7FFF...FFF8 (bits 254:3 set), x_p = 9, noncanon = 0, out_valid 2 edges after the 64th byte.
REQ-030: Scalar bytes all 0x00, u bytes all 0xFF -> k = 2^254, masked u = 2^255-1, x_p = 18, noncanon = 1.
REQ-031: u = p (0xED, thirty bytes of 0xFF, 0x7F) -> x_p = 0, noncanon = 1; u = p-1 (first byte 0xEC) -> x_p = p-1, noncanon = 0.
REQ-032: out_ready held 0 for 10 cycles in HOLD -> out_valid stays 1, in_ready = 0, outputs unchanged, in_valid bytes not consumed; raising out_ready completes the handoff in 1 edge.
REQ-033: Random in_valid gaps across a frame -> result identical to a gap-free frame; rst asserted after 20 bytes -> out_valid never rises for that frame, and the following full frame produces correct k and x_p.
REQ-034: Back-to-back frames with out_ready tied to 1 -> one out_valid pulse per 64 bytes; the second frame's values replace the first.
